// File: rtl/board_render_pkg.sv
// Shared types, fixed colours and helpers for the playfield renderer.
package board_render_pkg;

  typedef enum logic [2:0] {
    EMPTY,
    BORDER,
    GRID,
    GHOST,
    PIECE,
    LOCKED
  } cell_class_t;

  localparam logic [23:0] RGB_EMPTY  = 24'h000000;
  localparam logic [23:0] RGB_BORDER = 24'hC8C8C8;
  localparam logic [23:0] RGB_GRID   = 24'h202020;
  localparam logic [23:0] RGB_GHOST  = 24'h404040;

  function automatic logic [23:0] palette(input int unsigned id);
    case (id)
      0:       palette = 24'h000000;
      1:       palette = 24'h00FFFF;
      2:       palette = 24'h0000FF;
      3:       palette = 24'hFF8000;
      4:       palette = 24'hFFFF00;
      5:       palette = 24'h00FF00;
      6:       palette = 24'h8000FF;
      7:       palette = 24'hFF0000;
      default: palette = 24'hFFFFFF;
    endcase
  endfunction

  // Bit offset of coordinate k in a packed {y,x} list; is_y selects the y field.
  function automatic int unsigned coord_lsb(input int unsigned k, input int unsigned cw,
                                            input logic is_y);
    coord_lsb = k * 2 * cw + (is_y ? cw : 0);
  endfunction

endpackage

// File: rtl/board_render_cell_match.sv
// Hit when (cx,cy) equals any of NCELL packed piece coordinates.
module cell_match
  import board_render_pkg::*;
#(
  parameter int CW    = 5,
  parameter int NCELL = 4
) (
  input  logic [CW-1:0]         cx,
  input  logic [CW-1:0]         cy,
  input  logic [NCELL*2*CW-1:0] xy,
  output logic                  hit
);

  always_comb begin
    hit = 1'b0;
    for (int unsigned k = 0; k < NCELL; k++) begin
      if (xy[coord_lsb(k, CW, 1'b0) +: CW] == cx && xy[coord_lsb(k, CW, 1'b1) +: CW] == cy)
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/board_render.sv
// Tetris playfield renderer: 3-stage pixel pipeline between sync generator and DVI encoder.
module board_render
  import board_render_pkg::*;
#(
  parameter int H_RES     = 1024,
  parameter int V_RES     = 768,
  parameter int CELL_LOG2 = 5,
  parameter int BOARD_W   = 10,
  parameter int BOARD_H   = 20,
  parameter int ORG_X     = 0,
  parameter int ORG_Y     = 0,
  parameter int ID_W      = 4,
  parameter int CW        = 5,
  parameter int NCELL     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_sync_vs,
  input  logic                          i_sync_hs,
  input  logic                          i_sync_va,
  input  logic                          i_sync_ha,
  input  logic                          i_sync_de,
  input  logic [BOARD_W*BOARD_H*ID_W-1:0] i_board,
  input  logic [NCELL*2*CW-1:0]         i_piece_xy,
  input  logic [ID_W-1:0]               i_piece_id,
  input  logic [NCELL*2*CW-1:0]         i_ghost_xy,
  input  logic                          i_ghost_en,
  input  logic                          i_grid_en,
  output logic                          o_sync_vs,
  output logic                          o_sync_hs,
  output logic                          o_sync_va,
  output logic                          o_sync_ha,
  output logic                          o_sync_de,
  output logic [7:0]                    o_red,
  output logic [7:0]                    o_grn,
  output logic [7:0]                    o_blu,
  output logic                          o_frame_start
);

  localparam int          NCELLS  = BOARD_W * BOARD_H;
  localparam int          CIDX_W  = $clog2(NCELLS);
  localparam logic [10:0] H_LAST  = 11'(H_RES - 1);
  localparam logic [10:0] V_LAST  = 11'(V_RES - 1);
  localparam logic [11:0] ORG_X12 = 12'(ORG_X);
  localparam logic [11:0] ORG_Y12 = 12'(ORG_Y);
  localparam logic [10:0] PIX_W   = 11'(BOARD_W << CELL_LOG2);
  localparam logic [10:0] PIX_H   = 11'(BOARD_H << CELL_LOG2);

  logic [10:0] px, py;
  logic        aligned, vs_prev;

  logic [NCELLS*ID_W-1:0] sh_board;
  logic [NCELL*2*CW-1:0]  sh_piece_xy, sh_ghost_xy;
  logic [ID_W-1:0]        sh_piece_id;
  logic                   sh_ghost_en, sh_grid_en;

  logic [4:0] sync_d1, sync_d2, sync_d3;

  // Counters stay parked at 0 after a reset until a vsync realigns them.
  always_ff @(posedge clk) begin
    if (rst) begin
      px      <= '0;
      py      <= '0;
      aligned <= 1'b0;
    end else if (i_sync_vs) begin
      px      <= '0;
      py      <= '0;
      aligned <= 1'b1;
    end else if (i_sync_de && aligned) begin
      if (px == H_LAST) begin
        px <= '0;
        py <= (py == V_LAST) ? '0 : py + 11'd1;
      end else begin
        px <= px + 11'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_board    <= '0;
      sh_piece_xy <= '0;
      sh_piece_id <= '0;
      sh_ghost_xy <= '0;
      sh_ghost_en <= 1'b0;
      sh_grid_en  <= 1'b0;
    end else if (i_sync_vs) begin
      sh_board    <= i_board;
      sh_piece_xy <= i_piece_xy;
      sh_piece_id <= i_piece_id;
      sh_ghost_xy <= i_ghost_xy;
      sh_ghost_en <= i_ghost_en;
      sh_grid_en  <= i_grid_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev       <= 1'b0;
      o_frame_start <= 1'b0;
      sync_d1       <= '0;
      sync_d2       <= '0;
      sync_d3       <= '0;
    end else begin
      vs_prev       <= i_sync_vs;
      o_frame_start <= i_sync_vs && !vs_prev;
      sync_d1       <= {i_sync_vs, i_sync_hs, i_sync_va, i_sync_ha, i_sync_de};
      sync_d2       <= sync_d1;
      sync_d3       <= sync_d2;
    end
  end

  assign {o_sync_vs, o_sync_hs, o_sync_va, o_sync_ha, o_sync_de} = sync_d3;

  // S1: board-relative position
  logic [11:0]   dx, dy;
  logic          inb_s1, cell_edge_s1, lit_s1;
  logic [CW-1:0] cx_s1, cy_s1;

  always_comb begin
    dx = {1'b0, px} - ORG_X12;
    dy = {1'b0, py} - ORG_Y12;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inb_s1       <= 1'b0;
      cx_s1        <= '0;
      cy_s1        <= '0;
      cell_edge_s1 <= 1'b0;
      lit_s1       <= 1'b0;
    end else begin
      inb_s1       <= !dx[11] && !dy[11] && (dx[10:0] < PIX_W) && (dy[10:0] < PIX_H);
      cx_s1        <= dx[CELL_LOG2 +: CW];
      cy_s1        <= dy[CELL_LOG2 +: CW];
      cell_edge_s1 <= (dx[CELL_LOG2-1:0] == '0) || (dy[CELL_LOG2-1:0] == '0);
      lit_s1       <= i_sync_de && aligned;
    end
  end

  // S2: classification
  logic              piece_hit, ghost_hit;
  logic [ID_W-1:0]   board_cells [NCELLS];
  logic [CIDX_W-1:0] cell_idx;
  logic [ID_W-1:0]   cell_id;
  cell_class_t       cls_n, cls_s2;
  logic [ID_W-1:0]   id_n, id_s2;
  logic              lit_s2;

  cell_match #(.CW(CW), .NCELL(NCELL)) u_piece_match (
    .cx (cx_s1),
    .cy (cy_s1),
    .xy (sh_piece_xy),
    .hit(piece_hit)
  );

  cell_match #(.CW(CW), .NCELL(NCELL)) u_ghost_match (
    .cx (cx_s1),
    .cy (cy_s1),
    .xy (sh_ghost_xy),
    .hit(ghost_hit)
  );

  always_comb begin
    for (int unsigned c = 0; c < NCELLS; c++) board_cells[c] = sh_board[c*ID_W +: ID_W];
    cell_idx = CIDX_W'(int'(cy_s1) * BOARD_W + int'(cx_s1));
    cell_id  = inb_s1 ? board_cells[cell_idx] : '0;
  end

  always_comb begin
    cls_n = EMPTY;
    id_n  = '0;
    if (!inb_s1) begin
      cls_n = BORDER;
    end else if (piece_hit) begin
      cls_n = PIECE;
      id_n  = sh_piece_id;
    end else if (sh_ghost_en && ghost_hit) begin
      cls_n = GHOST;
    end else if (cell_id != '0) begin
      cls_n = LOCKED;
      id_n  = cell_id;
    end else if (sh_grid_en && cell_edge_s1) begin
      cls_n = GRID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cls_s2 <= EMPTY;
      id_s2  <= '0;
      lit_s2 <= 1'b0;
    end else begin
      cls_s2 <= cls_n;
      id_s2  <= id_n;
      lit_s2 <= lit_s1;
    end
  end

  // S3: colour lookup
  logic [23:0] rgb_n;

  always_comb begin
    rgb_n = RGB_EMPTY;
    case (cls_s2)
      BORDER:         rgb_n = RGB_BORDER;
      GRID:           rgb_n = RGB_GRID;
      GHOST:          rgb_n = RGB_GHOST;
      PIECE, LOCKED:  rgb_n = palette(32'(id_s2));
      default:        rgb_n = RGB_EMPTY;
    endcase
    if (!lit_s2) rgb_n = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) {o_red, o_grn, o_blu} <= '0;
    else     {o_red, o_grn, o_blu} <= rgb_n;
  end

endmodule

// File: tb/tb_board_render.sv
// Randomised frame-level check of board_render against a per-pixel reference model.
module tb_board_render;

  localparam int H   = 64;
  localparam int V   = 90;
  localparam int HB  = 6;
  localparam int CL  = 2;
  localparam int C   = 1 << CL;
  localparam int BW  = 10;
  localparam int BH  = 20;
  localparam int IDW = 4;
  localparam int CW  = 5;
  localparam int NC  = 4;
  localparam int OX  = 20;
  localparam int OY  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_sync_vs = 0, i_sync_hs = 0, i_sync_va = 0, i_sync_ha = 0, i_sync_de = 0;
  logic [BW*BH*IDW-1:0] i_board = '0;
  logic [NC*2*CW-1:0]   i_piece_xy = '0, i_ghost_xy = '0;
  logic [IDW-1:0]       i_piece_id = '0;
  logic                 i_ghost_en = 0, i_grid_en = 0;

  logic a_vs, a_hs, a_va, a_ha, a_de, a_fs;
  logic b_vs, b_hs, b_va, b_ha, b_de, b_fs;
  logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;

  always #5 clk = ~clk;

  board_render #(.H_RES(H), .V_RES(V), .CELL_LOG2(CL), .BOARD_W(BW), .BOARD_H(BH),
                 .ORG_X(0), .ORG_Y(0), .ID_W(IDW), .CW(CW), .NCELL(NC)) dut_a (
    .clk(clk), .rst(rst),
    .i_sync_vs(i_sync_vs), .i_sync_hs(i_sync_hs), .i_sync_va(i_sync_va),
    .i_sync_ha(i_sync_ha), .i_sync_de(i_sync_de),
    .i_board(i_board), .i_piece_xy(i_piece_xy), .i_piece_id(i_piece_id),
    .i_ghost_xy(i_ghost_xy), .i_ghost_en(i_ghost_en), .i_grid_en(i_grid_en),
    .o_sync_vs(a_vs), .o_sync_hs(a_hs), .o_sync_va(a_va), .o_sync_ha(a_ha), .o_sync_de(a_de),
    .o_red(a_r), .o_grn(a_g), .o_blu(a_b), .o_frame_start(a_fs)
  );

  board_render #(.H_RES(H), .V_RES(V), .CELL_LOG2(CL), .BOARD_W(BW), .BOARD_H(BH),
                 .ORG_X(OX), .ORG_Y(OY), .ID_W(IDW), .CW(CW), .NCELL(NC)) dut_b (
    .clk(clk), .rst(rst),
    .i_sync_vs(i_sync_vs), .i_sync_hs(i_sync_hs), .i_sync_va(i_sync_va),
    .i_sync_ha(i_sync_ha), .i_sync_de(i_sync_de),
    .i_board(i_board), .i_piece_xy(i_piece_xy), .i_piece_id(i_piece_id),
    .i_ghost_xy(i_ghost_xy), .i_ghost_en(i_ghost_en), .i_grid_en(i_grid_en),
    .o_sync_vs(b_vs), .o_sync_hs(b_hs), .o_sync_va(b_va), .o_sync_ha(b_ha), .o_sync_de(b_de),
    .o_red(b_r), .o_grn(b_g), .o_blu(b_b), .o_frame_start(b_fs)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Scene as driven (live) and as captured at the last vsync (snap).
  int live_bd [BW][BH];
  int snap_bd [BW][BH];
  int live_px [NC], live_py [NC], live_gx [NC], live_gy [NC];
  int snap_px [NC], snap_py [NC], snap_gx [NC], snap_gy [NC];
  int live_pid, snap_pid;
  bit live_gen, live_grid, snap_gen, snap_grid;

  bit       blackout  = 1'b1;
  bit       vs_prev_m = 1'b0;
  bit [2:0] rh        = 3'b111;

  typedef struct packed {
    logic [4:0]  sync;
    logic [23:0] a;
    logic [23:0] b;
  } exp_t;
  exp_t pipe [$];

  function automatic logic [23:0] pal(input int id);
    int r, g, b;
    case (id)
      0: begin r = 0;   g = 0;   b = 0;   end
      1: begin r = 0;   g = 255; b = 255; end
      2: begin r = 0;   g = 0;   b = 255; end
      3: begin r = 255; g = 128; b = 0;   end
      4: begin r = 255; g = 255; b = 0;   end
      5: begin r = 0;   g = 255; b = 0;   end
      6: begin r = 128; g = 0;   b = 255; end
      7: begin r = 255; g = 0;   b = 0;   end
      default: begin r = 255; g = 255; b = 255; end
    endcase
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  function automatic logic [23:0] ref_rgb(input int x, input int y, input int ox, input int oy);
    int dx, dy, cx, cy;
    dx = x - ox;
    dy = y - oy;
    if (dx < 0 || dy < 0 || dx >= BW * C || dy >= BH * C) return {8'd200, 8'd200, 8'd200};
    cx = dx / C;
    cy = dy / C;
    for (int k = 0; k < NC; k++)
      if (snap_px[k] == cx && snap_py[k] == cy) return pal(snap_pid);
    if (snap_gen)
      for (int k = 0; k < NC; k++)
        if (snap_gx[k] == cx && snap_gy[k] == cy) return {8'd64, 8'd64, 8'd64};
    if (snap_bd[cx][cy] != 0) return pal(snap_bd[cx][cy]);
    if (snap_grid && (dx % C == 0 || dy % C == 0)) return {8'd32, 8'd32, 8'd32};
    return 24'h0;
  endfunction

  task automatic take_snapshot();
    for (int x = 0; x < BW; x++)
      for (int y = 0; y < BH; y++) snap_bd[x][y] = live_bd[x][y];
    for (int k = 0; k < NC; k++) begin
      snap_px[k] = live_px[k];
      snap_py[k] = live_py[k];
      snap_gx[k] = live_gx[k];
      snap_gy[k] = live_gy[k];
    end
    snap_pid  = live_pid;
    snap_gen  = live_gen;
    snap_grid = live_grid;
  endtask

  task automatic apply_live();
    for (int x = 0; x < BW; x++)
      for (int y = 0; y < BH; y++) i_board[(y*BW+x)*IDW +: IDW] = IDW'(live_bd[x][y]);
    for (int k = 0; k < NC; k++) begin
      i_piece_xy[k*2*CW +: CW]      = CW'(live_px[k]);
      i_piece_xy[k*2*CW+CW +: CW]   = CW'(live_py[k]);
      i_ghost_xy[k*2*CW +: CW]      = CW'(live_gx[k]);
      i_ghost_xy[k*2*CW+CW +: CW]   = CW'(live_gy[k]);
    end
    i_piece_id = IDW'(live_pid);
    i_ghost_en = live_gen;
    i_grid_en  = live_grid;
  endtask

  task automatic directed_scene();
    for (int x = 0; x < BW; x++)
      for (int y = 0; y < BH; y++) live_bd[x][y] = 0;
    live_bd[9][19] = 7;
    live_bd[1][0]  = 3;
    for (int k = 0; k < NC; k++) begin
      live_px[k] = k;
      live_py[k] = 0;
      live_gx[k] = k + 4;
      live_gy[k] = 19;
    end
    live_pid  = 1;
    live_gen  = 1'b1;
    live_grid = 1'b1;
    apply_live();
  endtask

  task automatic random_scene();
    for (int x = 0; x < BW; x++)
      for (int y = 0; y < BH; y++)
        live_bd[x][y] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : 0;
    for (int k = 0; k < NC; k++) begin
      live_px[k] = $urandom_range(0, 11);
      live_py[k] = ($urandom_range(0, 5) == 0) ? 31 : int'($urandom_range(0, 21));
      live_gx[k] = $urandom_range(0, 11);
      live_gy[k] = ($urandom_range(0, 5) == 0) ? 31 : int'($urandom_range(0, 21));
    end
    live_pid  = $urandom_range(0, 15);
    live_gen  = 1'($urandom_range(0, 1));
    live_grid = 1'($urandom_range(0, 1));
    apply_live();
  endtask

  task automatic step(input logic vs, input logic hs, input logic va, input logic ha,
                      input logic de, input int x, input int y, input logic r);
    exp_t e;
    bit   fs_exp;
    rst       = r;
    i_sync_vs = vs;
    i_sync_hs = hs;
    i_sync_va = va;
    i_sync_ha = ha;
    i_sync_de = de;
    e.sync = {vs, hs, va, ha, de};
    e.a    = (de && !blackout) ? ref_rgb(x, y, 0, 0) : 24'h0;
    e.b    = (de && !blackout) ? ref_rgb(x, y, OX, OY) : 24'h0;
    pipe.push_back(e);
    @(posedge clk);
    if (r) blackout = 1'b1;
    else if (vs) begin
      take_snapshot();
      blackout = 1'b0;
    end
    fs_exp    = !r && vs && !vs_prev_m;
    vs_prev_m = !r && vs;
    rh        = {rh[1:0], r};
    @(negedge clk);
    chk("frame_start_a", 32'(a_fs), 32'(fs_exp));
    chk("frame_start_b", 32'(b_fs), 32'(fs_exp));
    if (pipe.size() == 3) begin
      e = pipe.pop_front();
      if (rh != 3'b000) e = '0;
    end else begin
      e = '0;
    end
    chk("sync_a", 32'({a_vs, a_hs, a_va, a_ha, a_de}), 32'(e.sync));
    chk("sync_b", 32'({b_vs, b_hs, b_va, b_ha, b_de}), 32'(e.sync));
    chk("rgb_a", 32'({a_r, a_g, a_b}), 32'(e.a));
    chk("rgb_b", 32'({b_r, b_g, b_b}), 32'(e.b));
  endtask

  task automatic frame(input int chg_line, input int rst_line, input int rst_x);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int y = 0; y < V; y++) begin
      if (y == chg_line) random_scene();
      for (int x = 0; x < H; x++)
        step(0, 0, 1, 1, 1, x, y, (y == rst_line && x == rst_x) ? 1'b1 : 1'b0);
      for (int i = 0; i < HB; i++) step(0, (i < 2) ? 1'b1 : 1'b0, 1, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    @(negedge clk);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
    directed_scene();
    frame(-1, -1, 0);
    live_grid = 1'b0;
    apply_live();
    frame(-1, -1, 0);
    random_scene();
    frame(37, -1, 0);
    frame(-1, -1, 0);
    random_scene();
    frame(-1, 40, 30);
    frame(-1, -1, 0);
    random_scene();
    frame(-1, -1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/board_render.md
Name: board_render

Overview:
- Parametrised pixel renderer for the tetris playfield in the DVI output path, between the sync generator and the DVI encoder.
- Tracks pixel position from the incoming sync/DE stream.
- Maps each pixel to a board cell and classifies it: active piece, ghost piece, locked cell, empty cell, grid line or border.
- Outputs a palette colour with the sync signals delayed to match.
- Board geometry, cell size, origin and colour-id width are parameters.
- Board and piece state are snapshotted once per frame, so no tearing.

Parameters:
- H_RES, 1024: active pixels per line.
- V_RES, 768: active lines per frame.
- CELL_LOG2, 5: cell edge is 2^CELL_LOG2 pixels.
- BOARD_W, 10: board width in cells.
- BOARD_H, 20: board height in cells.
- ORG_X, 0: left pixel of the board.
- ORG_Y, 0: top line of the board.
- ID_W, 4: bits per cell colour id.
- CW, 5: bits per piece cell coordinate.
- NCELL, 4: cells per piece.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- i_sync_vs, i_sync_hs, i_sync_va, i_sync_ha, i_sync_de  in  1 each  timing from the sync generator
- i_board  in  BOARD_W*BOARD_H*ID_W  locked cells, row-major; cell (x,y) at bit offset (y*BOARD_W+x)*ID_W; id 0 = empty
- i_piece_xy  in  NCELL*2*CW  absolute piece cells; cell k: x at [k*2*CW +: CW], y at [k*2*CW+CW +: CW]
- i_piece_id  in  ID_W  colour id of the active piece
- i_ghost_xy  in  NCELL*2*CW  ghost (drop-preview) cells, same layout
- i_ghost_en  in  1  enable ghost drawing
- i_grid_en  in  1  enable grid lines in empty cells
- o_sync_vs, o_sync_hs, o_sync_va, o_sync_ha, o_sync_de  out  1 each  inputs delayed 3 cycles
- o_red, o_grn, o_blu  out  8 each  pixel colour
- o_frame_start  out  1  one-cycle pulse on the rising edge of i_sync_vs

Behaviour:
- Reset: all outputs 0, pixel counters 0, snapshot registers 0, pipeline flushed. A reset mid-frame gives black output and counters at 0 until the next i_sync_vs realigns them.
- Pixel counters px (11 bit) and py (11 bit):
  - Any cycle with i_sync_vs=1: px=py=0.
  - Else, on a cycle with i_sync_de=1: the counters hold the current pixel's position and advance afterwards.
  - px wraps H_RES-1 -> 0 and then increments py. py wraps V_RES-1 -> 0.
  - DE=0 cycles hold both counters.
- Snapshot: every cycle i_sync_vs=1, copy i_board, i_piece_xy, i_piece_id, i_ghost_xy, i_ghost_en and i_grid_en into shadow registers. Rendering uses only the shadows. Input changes while vs=0 are invisible until the next frame.
- o_frame_start: registered. High for exactly one cycle after the cycle where i_sync_vs rises 0->1.
- Pipeline, 3 stages, latency exactly 3 clocks. The sync outputs are a 3-deep shift of the inputs.
  - S1: dx=px-ORG_X, dy=py-ORG_Y, 12-bit signed.
    - inb = dx>=0, dy>=0, dx < BOARD_W<<CELL_LOG2, dy < BOARD_H<<CELL_LOG2.
    - cx=dx>>CELL_LOG2, cy=dy>>CELL_LOG2.
    - edge = low CELL_LOG2 bits of dx or of dy equal 0.
  - S2: classify, highest priority first:
    - !inb -> BORDER
    - any piece cell equals (cx,cy) -> PIECE
    - ghost enabled and any ghost cell matches -> GHOST
    - board id != 0 -> LOCKED(id)
    - grid enabled and edge -> GRID
    - else EMPTY
    - Piece/ghost coordinates >= BOARD_W/BOARD_H never match, since they lie outside the inb region. This is used for spawn above the board.
  - S3: colour lookup:
    - EMPTY = 0,0,0
    - BORDER = 200,200,200
    - GRID = 32,32,32
    - GHOST = 64,64,64
    - PIECE = palette[i_piece_id]
    - LOCKED = palette[id]
  - Pixels with delayed DE=0 output RGB 0.
- Palette, indexed by id:
  - 0 = 0,0,0
  - 1 = 0,255,255
  - 2 = 0,0,255
  - 3 = 255,128,0
  - 4 = 255,255,0
  - 5 = 0,255,0
  - 6 = 128,0,255
  - 7 = 255,0,0
  - 8 and above = 255,255,255

Decomposition:
- Shared package board_render_pkg holds:
  - class enum: EMPTY, BORDER, GRID, GHOST, PIECE, LOCKED
  - fixed colour constants
  - palette function
  - coordinate-unpack helper
- One sub-module, cell_match: compares (cx,cy) against NCELL packed coordinates and returns a hit. Instantiated twice, once for the piece and once for the ghost.

Test Plan:
- Defaults, empty board, piece at (0,0),(1,0),(2,0),(3,0) id 1: pixel (0,0) -> RGB 0,255,255 three cycles after its DE. Pixel (128,0) -> 0,0,0. Pixel (320,0) -> 200,200,200.
- Board cell (9,19)=7, grid on: pixel (300,620) -> 255,0,0. Pixel (288,600), an empty cell edge -> 32,32,32. Grid off -> 0,0,0.
- Ghost enabled at row 19 with the piece at row 0: row-19 cells -> 64,64,64. Piece cell overlapping a locked id-3 cell -> piece colour.
- Change i_board mid-frame (vs=0): current frame unchanged, new value shown after the next vs pulse. o_frame_start is exactly 1 cycle per vs rise.
- ORG_X=352, ORG_Y=64: pixel (351,64) -> border. Pixel (352,64) -> cell (0,0). Piece y=31 is never drawn.
- Assert rst mid-line: outputs 0 on the next cycle. Correct image is restored from the frame after the next vs.
